// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt dispatch sequencer.
// Holds the state encoding, parameter defaults and the vector address helper.
package irq_pkg;

  localparam int          NUM_IRQ_DEF  = 5;
  localparam logic [15:0] VEC_BASE_DEF = 16'h0040;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_W0,
    ST_W1,
    ST_PUSH_H,
    ST_PUSH_L,
    ST_JUMP
  } state_t;

  // Source i vectors to base + 8*i.
  function automatic logic [15:0] vec_addr(input logic [15:0] base, input logic [7:0] idx);
    return base + {5'b0, idx, 3'b000};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Priority encoder: lowest set bit of pend wins; outputs one-hot, index and valid.
// Latency: combinational. Backpressure: none.
// Pure function of pend, no state.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] pend,
  output logic [NUM_IRQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               vld
);

  // Scan downwards so the lowest set index is the last assignment.
  always_comb begin
    onehot = '0;
    idx    = '0;
    vld    = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
        vld       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_dispatch_seq.sv
// SM83 interrupt dispatch sequencer: IME/EI delay, HALT wake, W0-W1-PUSH_H-PUSH_L-JUMP.
// Latency: INSTR_BOUND to PC_LOAD is 5 cycles; each BUS_ACK-low cycle in a push adds one.
// Backpressure: pushes hold BUS_REQ/BUS_WR_DATA until BUS_ACK. IRQ_CANCEL_EN: late vector pick.
module irq_dispatch_seq
  import irq_pkg::*;
#(
  parameter int          NUM_IRQ  = NUM_IRQ_DEF,
  parameter logic [15:0] VEC_BASE = VEC_BASE_DEF
) (
  input  logic               CLK,
  input  logic               nRESET,
  input  logic [NUM_IRQ-1:0] IRQ_PEND,
  input  logic               INSTR_BOUND,
  input  logic               EI_EXEC,
  input  logic               DI_EXEC,
  input  logic               RETI_EXEC,
  input  logic               HALT_EXEC,
  input  logic [15:0]        PC,
  input  logic               BUS_ACK,
  output logic               BUS_REQ,
  output logic [7:0]         BUS_WR_DATA,
  output logic               SP_DEC,
  output logic [NUM_IRQ-1:0] IRQ_ACK,
  output logic               PC_LOAD,
  output logic [15:0]        PC_VEC,
  output logic               BUSY,
  output logic               HALTED,
  output logic               IME
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  state_t               state, state_nxt;
  logic                 ime, ei_dly;
  logic                 take;
  logic                 sel_load;
  logic [15:0]          pc_hold;
  logic [NUM_IRQ-1:0]   pend_oh, sel_oh;
  logic [IDX_W-1:0]     pend_idx, sel_idx;
  logic                 pend_vld, sel_vld;

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) u_prio (
    .pend   (IRQ_PEND),
    .onehot (pend_oh),
    .idx    (pend_idx),
    .vld    (pend_vld)
  );

`ifdef IRQ_CANCEL_EN
  // The high push may overwrite IE, so the source is chosen only once it lands.
  assign sel_load = (state == ST_PUSH_H) && BUS_ACK;
`else
  assign sel_load = take;
`endif

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    take        = 1'b0;
    BUS_REQ     = 1'b0;
    BUS_WR_DATA = 8'h00;
    SP_DEC      = 1'b0;
    IRQ_ACK     = '0;
    PC_LOAD     = 1'b0;
    PC_VEC      = 16'h0000;
    BUSY        = (state != ST_IDLE) && (state != ST_HALT);
    HALTED      = (state == ST_HALT);
    case (state)
      ST_IDLE: begin
        if (INSTR_BOUND && ime && pend_vld) begin
          take      = 1'b1;
          state_nxt = ST_W0;
        end else if (HALT_EXEC) begin
          state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        // Wake-up ignores IME; IME only decides whether a dispatch follows.
        if (pend_vld) begin
          take      = ime;
          state_nxt = ime ? ST_W0 : ST_IDLE;
        end
      end
      ST_W0: state_nxt = ST_W1;
      ST_W1: begin
        SP_DEC    = 1'b1;
        state_nxt = ST_PUSH_H;
      end
      ST_PUSH_H: begin
        BUS_REQ     = 1'b1;
        BUS_WR_DATA = pc_hold[15:8];
        if (BUS_ACK) begin
          SP_DEC    = 1'b1;
          state_nxt = ST_PUSH_L;
        end
      end
      ST_PUSH_L: begin
        BUS_REQ     = 1'b1;
        BUS_WR_DATA = pc_hold[7:0];
        if (BUS_ACK) state_nxt = ST_JUMP;
      end
      ST_JUMP: begin
        PC_LOAD = 1'b1;
        if (sel_vld) begin
          PC_VEC  = vec_addr(VEC_BASE, 8'(sel_idx));
          IRQ_ACK = sel_oh;
        end
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Later assignments take precedence: DI beats EI, dispatch clears IME last.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      ime    <= 1'b0;
      ei_dly <= 1'b0;
    end else begin
      if (INSTR_BOUND && !BUSY && ei_dly) begin
        ime    <= 1'b1;
        ei_dly <= 1'b0;
      end
      if (RETI_EXEC) ime <= 1'b1;
      if (EI_EXEC) ei_dly <= 1'b1;
      if (DI_EXEC) begin
        ime    <= 1'b0;
        ei_dly <= 1'b0;
      end
      if (take) ime <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      pc_hold <= 16'h0000;
      sel_oh  <= '0;
      sel_idx <= '0;
      sel_vld <= 1'b0;
    end else begin
      if (take) pc_hold <= PC;
      if (sel_load) begin
        sel_oh  <= pend_oh;
        sel_idx <= pend_idx;
        sel_vld <= pend_vld;
      end
    end
  end

  assign IME = ime;

endmodule

// File: tb/tb_irq_dispatch_seq.sv
// Self-checking bench for irq_dispatch_seq: scoreboard of expected pushes/vector/ack
// popped at each PC_LOAD, plus directed checks on IME, HALT, stall and reset.
module tb_irq_dispatch_seq;

  logic        CLK = 1'b0;
  logic        nRESET;
  logic [4:0]  IRQ_PEND;
  logic        INSTR_BOUND, EI_EXEC, DI_EXEC, RETI_EXEC, HALT_EXEC;
  logic [15:0] PC;
  logic        BUS_ACK;
  logic        BUS_REQ;
  logic [7:0]  BUS_WR_DATA;
  logic        SP_DEC;
  logic [4:0]  IRQ_ACK;
  logic        PC_LOAD;
  logic [15:0] PC_VEC;
  logic        BUSY, HALTED, IME;

  irq_dispatch_seq #(.NUM_IRQ(5), .VEC_BASE(16'h0040)) dut (
    .CLK         (CLK),
    .nRESET      (nRESET),
    .IRQ_PEND    (IRQ_PEND),
    .INSTR_BOUND (INSTR_BOUND),
    .EI_EXEC     (EI_EXEC),
    .DI_EXEC     (DI_EXEC),
    .RETI_EXEC   (RETI_EXEC),
    .HALT_EXEC   (HALT_EXEC),
    .PC          (PC),
    .BUS_ACK     (BUS_ACK),
    .BUS_REQ     (BUS_REQ),
    .BUS_WR_DATA (BUS_WR_DATA),
    .SP_DEC      (SP_DEC),
    .IRQ_ACK     (IRQ_ACK),
    .PC_LOAD     (PC_LOAD),
    .PC_VEC      (PC_VEC),
    .BUSY        (BUSY),
    .HALTED      (HALTED),
    .IME         (IME)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] vec;
    logic [4:0]  ack;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] got_b[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         load_cnt = 0;
  int         breq_cnt = 0;
  int         spdec_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: collects accepted push bytes, compares at PC_LOAD.
  always @(negedge CLK) begin
    if (!nRESET) begin
      got_b.delete();
    end else begin
      if (BUS_REQ) breq_cnt++;
      if (SP_DEC) spdec_cnt++;
      if (BUS_REQ && BUS_ACK) got_b.push_back(BUS_WR_DATA);
      if (PC_LOAD) begin
        load_cnt++;
        chk("sb_expected_load", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("push_cnt", got_b.size(), 2);
          if (got_b.size() == 2) begin
            chk("push_hi", got_b[0], mon_e.hi);
            chk("push_lo", got_b[1], mon_e.lo);
          end
          chk("pc_vec", PC_VEC, mon_e.vec);
          chk("irq_ack", IRQ_ACK, mon_e.ack);
        end
        got_b.delete();
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // s = {EI, DI, RETI, HALT, BOUND}, held for one sampled edge.
  task automatic strobe(input logic [4:0] s);
    {EI_EXEC, DI_EXEC, RETI_EXEC, HALT_EXEC, INSTR_BOUND} = s;
    cyc(1);
    {EI_EXEC, DI_EXEC, RETI_EXEC, HALT_EXEC, INSTR_BOUND} = 5'b0;
  endtask

  // Optionally raises INSTR_BOUND for one edge, then waits (bounded) for PC_LOAD.
  task automatic wait_load(input string tag, input bit use_bound, input int exp_lat);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    if (use_bound) INSTR_BOUND = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      if (PC_LOAD) seen = 1'b1;
      else         lat++;
      if (i == 0) begin
        @(posedge CLK);
        #1;
        INSTR_BOUND = 1'b0;
      end
    end
    chk({tag, "_seen"}, seen, 1);
    if (exp_lat >= 0) chk({tag, "_lat"}, lat, exp_lat);
    cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base_load, base_breq, base_sp;
    bit   seen;
    exp_t e;

    nRESET = 1'b0;
    IRQ_PEND = '0;
    {EI_EXEC, DI_EXEC, RETI_EXEC, HALT_EXEC, INSTR_BOUND} = 5'b0;
    PC = 16'h0000;
    BUS_ACK = 1'b1;
    cyc(3);
    chk("rst_outs", {BUS_REQ, BUS_WR_DATA, SP_DEC, IRQ_ACK, PC_LOAD, PC_VEC, BUSY, HALTED, IME}, 0);
    nRESET = 1'b1;
    cyc(2);

    // Basic dispatch, zero wait states.
    strobe(5'b00100);
    chk("reti_ime", IME, 1);
    IRQ_PEND = 5'b00100;
    PC = 16'h1234;
    base_sp = spdec_cnt;
    e = '{hi: 8'h12, lo: 8'h34, vec: 16'h0050, ack: 5'b00100};
    exp_q.push_back(e);
    wait_load("disp1", 1'b1, 5);
    chk("disp1_ime", IME, 0);
    chk("disp1_spdec", spdec_cnt - base_sp, 2);
    chk("disp1_idle", BUSY, 0);

    // Priority: lowest index wins.
    strobe(5'b00100);
    IRQ_PEND = 5'b10001;
    PC = 16'hABCD;
    e = '{hi: 8'hAB, lo: 8'hCD, vec: 16'h0040, ack: 5'b00001};
    exp_q.push_back(e);
    wait_load("prio", 1'b1, 5);

    // EI delay: first boundary promotes IME but does not dispatch.
    IRQ_PEND = 5'b00001;
    base_load = load_cnt;
    strobe(5'b10000);
    strobe(5'b00001);
    cyc(2);
    chk("ei_first_busy", BUSY, 0);
    chk("ei_first_ime", IME, 1);
    chk("ei_first_load", load_cnt - base_load, 0);
    PC = 16'h0100;
    e = '{hi: 8'h01, lo: 8'h00, vec: 16'h0040, ack: 5'b00001};
    exp_q.push_back(e);
    wait_load("ei_second", 1'b1, 5);

    // EI then DI: no dispatch at either boundary.
    base_load = load_cnt;
    strobe(5'b10000);
    strobe(5'b01000);
    strobe(5'b00001);
    cyc(2);
    strobe(5'b00001);
    cyc(8);
    chk("di_load", load_cnt - base_load, 0);
    chk("di_ime", IME, 0);

    // EI and DI together: DI wins.
    strobe(5'b11000);
    strobe(5'b00001);
    cyc(2);
    chk("eidi_ime", IME, 0);
    IRQ_PEND = '0;

    // HALT with IME=0: wake to IDLE, no dispatch.
    strobe(5'b00010);
    chk("halt0_halted", HALTED, 1);
    chk("halt0_busy", BUSY, 0);
    base_breq = breq_cnt;
    IRQ_PEND = 5'b00010;
    cyc(1);
    chk("halt0_wake", {HALTED, BUSY}, 0);
    cyc(4);
    chk("halt0_noreq", breq_cnt - base_breq, 0);
    chk("halt0_ime", IME, 0);
    IRQ_PEND = '0;

    // HALT with IME=1: wake straight into dispatch.
    strobe(5'b00100);
    strobe(5'b00010);
    chk("halt1_halted", HALTED, 1);
    PC = 16'h2000;
    e = '{hi: 8'h20, lo: 8'h00, vec: 16'h0048, ack: 5'b00010};
    exp_q.push_back(e);
    IRQ_PEND = 5'b00010;
    wait_load("halt1", 1'b0, -1);
    chk("halt1_ime", IME, 0);
    IRQ_PEND = '0;

    // Pending drops while PUSH_H is stalled.
    strobe(5'b00100);
    IRQ_PEND = 5'b01000;
    PC = 16'h4321;
    BUS_ACK = 1'b0;
    strobe(5'b00001);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK);
      if (BUS_REQ) seen = 1'b1;
    end
    chk("cancel_req_seen", seen, 1);
    cyc(2);
    chk("cancel_hold", {BUS_REQ, BUS_WR_DATA}, {1'b1, 8'h43});
`ifdef IRQ_CANCEL_EN
    e = '{hi: 8'h43, lo: 8'h21, vec: 16'h0000, ack: 5'b00000};
`else
    e = '{hi: 8'h43, lo: 8'h21, vec: 16'h0058, ack: 5'b01000};
`endif
    exp_q.push_back(e);
    IRQ_PEND = '0;
    BUS_ACK = 1'b1;
    wait_load("cancel", 1'b0, -1);

    // Stall in PUSH_L, then reset mid-dispatch.
    strobe(5'b00100);
    IRQ_PEND = 5'b00100;
    PC = 16'h1234;
    base_load = load_cnt;
    strobe(5'b00001);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK);
      if (BUS_REQ) seen = 1'b1;
    end
    chk("stall_req_seen", seen, 1);
    @(posedge CLK);
    #1;
    BUS_ACK = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("stall_hold", {BUS_REQ, BUS_WR_DATA, PC_LOAD}, {1'b1, 8'h34, 1'b0});
    end
    nRESET = 1'b0;
    #1;
    chk("midrst_outs", {BUS_REQ, BUS_WR_DATA, SP_DEC, IRQ_ACK, PC_LOAD, PC_VEC, BUSY, HALTED, IME}, 0);
    BUS_ACK = 1'b1;
    cyc(2);
    nRESET = 1'b1;
    strobe(5'b00001);
    cyc(8);
    chk("postrst_load", load_cnt - base_load, 0);
    chk("postrst_idle", {BUSY, IME}, 0);

    chk("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
